// File: rtl/memoria_instrucao_carregavel.sv
// Run-time loadable instruction memory: cleared to NOP after reset, loaded over a
// valid/ready port, and read by byte PC with a one-cycle registered fetch.
module memoria_instrucao_carregavel #(
  parameter int unsigned             LARGURA_DADO = 32,
  parameter int unsigned             PROFUNDIDADE = 256,
  parameter logic [LARGURA_DADO-1:0] NOP          = LARGURA_DADO'(32'h00000033)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              modo_carga,
  input  logic                              carga_valida,
  output logic                              carga_pronto,
  input  logic [$clog2(PROFUNDIDADE)-1:0]   carga_endereco,
  input  logic [LARGURA_DADO-1:0]           carga_dado,
  input  logic                              busca_valida,
  output logic                              busca_pronto,
  input  logic [31:0]                       pc,
  output logic [LARGURA_DADO-1:0]           instrucao,
  output logic                              instrucao_valida,
  output logic                              erro_desalinhado,
  output logic                              erro_fora_faixa,
  output logic                              ocupada
);

  localparam int unsigned LARGURA_END = $clog2(PROFUNDIDADE);

  typedef enum logic [1:0] {
    LIMPA    = 2'd0,
    EXECUCAO = 2'd1,
    CARGA    = 2'd2
  } estado_t;

  estado_t                 estado_q, estado_d;
  logic [LARGURA_END-1:0]  contador_q, contador_d;
  logic [LARGURA_DADO-1:0] instrucao_q, instrucao_d;
  logic                    valida_q, valida_d;
  logic                    desal_q, desal_d;
  logic                    fora_q, fora_d;
  logic                    carga_pronto_q, carga_pronto_d;
  logic                    busca_pronto_q, busca_pronto_d;
  logic                    ocupada_q, ocupada_d;

  logic [LARGURA_DADO-1:0] mem_q [PROFUNDIDADE];

  logic                    esc_en_c;
  logic [LARGURA_END-1:0]  esc_idx_c;
  logic [LARGURA_DADO-1:0] esc_dado_c;
  logic                    busca_aceita_c;
  logic                    carga_aceita_c;

  // Next state, clear/load write port and fetch result
  always_comb begin
    estado_d       = estado_q;
    contador_d     = contador_q;
    instrucao_d    = instrucao_q;
    valida_d       = 1'b0;
    desal_d        = 1'b0;
    fora_d         = 1'b0;
    esc_en_c       = 1'b0;
    esc_idx_c      = contador_q;
    esc_dado_c     = NOP;
    busca_aceita_c = busca_valida & busca_pronto_q;
    carga_aceita_c = carga_valida & carga_pronto_q;

    case (estado_q)
      LIMPA: begin
        esc_en_c   = 1'b1;
        contador_d = contador_q + LARGURA_END'(1);
        if (contador_q == LARGURA_END'(PROFUNDIDADE - 1)) begin
          estado_d = modo_carga ? CARGA : EXECUCAO;
        end
      end
      EXECUCAO: begin
        if (modo_carga) estado_d = CARGA;
      end
      CARGA: begin
        if (!modo_carga) estado_d = EXECUCAO;
        if (carga_aceita_c) begin
          esc_en_c   = 1'b1;
          esc_idx_c  = carga_endereco;
          esc_dado_c = carga_dado;
        end
      end
      default: estado_d = LIMPA;
    endcase

    // Misalignment wins over range; both yield NOP
    if (busca_aceita_c) begin
      valida_d = 1'b1;
      if (pc[1:0] != 2'b00) begin
        desal_d     = 1'b1;
        instrucao_d = NOP;
      end else if (pc[31:2] >= 30'(PROFUNDIDADE)) begin
        fora_d      = 1'b1;
        instrucao_d = NOP;
      end else begin
        instrucao_d = mem_q[pc[LARGURA_END+1:2]];
      end
    end

    busca_pronto_d = (estado_d == EXECUCAO);
    carga_pronto_d = (estado_d == CARGA);
    ocupada_d      = (estado_d == LIMPA);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q       <= LIMPA;
      contador_q     <= '0;
      instrucao_q    <= NOP;
      valida_q       <= 1'b0;
      desal_q        <= 1'b0;
      fora_q         <= 1'b0;
      carga_pronto_q <= 1'b0;
      busca_pronto_q <= 1'b0;
      ocupada_q      <= 1'b1;
    end else begin
      estado_q       <= estado_d;
      contador_q     <= contador_d;
      instrucao_q    <= instrucao_d;
      valida_q       <= valida_d;
      desal_q        <= desal_d;
      fora_q         <= fora_d;
      carga_pronto_q <= carga_pronto_d;
      busca_pronto_q <= busca_pronto_d;
      ocupada_q      <= ocupada_d;
    end
  end

  // Storage array; contents are rebuilt by LIMPA rather than reset
  always_ff @(posedge clk) begin
    if (esc_en_c) mem_q[esc_idx_c] <= esc_dado_c;
  end

  assign instrucao        = instrucao_q;
  assign instrucao_valida = valida_q;
  assign erro_desalinhado = desal_q;
  assign erro_fora_faixa  = fora_q;
  assign carga_pronto     = carga_pronto_q;
  assign busca_pronto     = busca_pronto_q;
  assign ocupada          = ocupada_q;

endmodule
